// File: rtl/dma_pkg.sv
// Shared definitions for the DMA burst controller: opcode constants, FSM state
// encoding and the START-opcode helper.
package dma_pkg;

  localparam int unsigned OpcodeW = 3;

  localparam logic [OpcodeW-1:0] OpNop       = 3'd0;
  localparam logic [OpcodeW-1:0] OpFetchBase = 3'd1;
  localparam logic [OpcodeW-1:0] OpMax       = 3'd7;

  typedef enum logic [1:0] {
    StIdle,
    StXfer,
    StDone
  } dma_state_e;

  // START sits directly above the last fetch opcode.
  function automatic logic [OpcodeW-1:0] start_opcode(input int unsigned num_ch);
    return OpcodeW'(num_ch + 1);
  endfunction

endpackage

// File: rtl/dma_cmd_decode.sv
// Combinational opcode decoder: one-hot fetch channel plus START / illegal / NOP flags.
module dma_cmd_decode
  import dma_pkg::*;
#(
  parameter int unsigned NUM_CH = 3
) (
  input  logic [OpcodeW-1:0] opcode,
  output logic [NUM_CH-1:0]  ch_onehot,
  output logic               is_start,
  output logic               is_illegal,
  output logic               is_nop
);

  logic [OpcodeW-1:0] start_op;
  assign start_op = start_opcode(NUM_CH);

  // Map opcodes 1..NUM_CH onto channel bits 0..NUM_CH-1.
  always_comb begin
    ch_onehot = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      ch_onehot[i] = (opcode == OpcodeW'(i + int'(OpFetchBase)));
    end
  end

  // Everything above START up to OpMax is illegal.
  always_comb begin
    is_nop     = (opcode == OpNop);
    is_start   = (opcode == start_op);
    is_illegal = (opcode > start_op) && (opcode <= OpMax);
  end

endmodule

// File: rtl/dma_burst_ctrl.sv
// DMA burst controller: accepts host command bytes, runs address bursts on one of
// NUM_CH fetch channels and pulses start/err/done. All outputs are registered.
// Optional feature macro DMA_BURST_EN: when defined, a fetch runs len_in+1 beats;
// when undefined, every fetch is a single beat and no length counter exists.
module dma_burst_ctrl
  import dma_pkg::*;
#(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        uio_in,
  input  logic [LEN_W-1:0]  len_in,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              mem_ready,
  output logic [NUM_CH-1:0] fetch,
  output logic              dma_valid,
  output logic [ADDR_W-1:0] dma_address,
  output logic              start,
  output logic              busy,
  output logic              done,
  output logic              err
);

  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NUM_CH-1:0] ch_q, ch_d;
  logic              start_q, start_d;
  logic              err_q, err_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;
  logic              last_beat;

  logic [NUM_CH-1:0] dec_ch;
  logic              dec_is_start;
  logic              dec_is_illegal;
  logic              dec_is_nop;

  dma_cmd_decode #(
    .NUM_CH (NUM_CH)
  ) u_cmd_decode (
    .opcode     (uio_in[7:5]),
    .ch_onehot  (dec_ch),
    .is_start   (dec_is_start),
    .is_illegal (dec_is_illegal),
    .is_nop     (dec_is_nop)
  );

`ifdef DMA_BURST_EN
  // Remaining beats minus one; zero means the current beat is the last.
  logic [LEN_W-1:0] cnt_q, cnt_d;
  assign last_beat = (cnt_q == '0);

  // NOP needs no action; high uio_in bits above the address are don't-care.
  logic unused_in;
  assign unused_in = ^{uio_in, dec_is_nop};
`else
  assign last_beat = 1'b1;

  // Length is meaningless without bursts; NOP and upper address bits are don't-care.
  logic unused_in;
  assign unused_in = ^{uio_in, len_in, dec_is_nop};
`endif

  // Next-state logic: command acceptance in IDLE, beat stepping in XFER.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ch_d    = ch_q;
    start_d = 1'b0;
    err_d   = 1'b0;
`ifdef DMA_BURST_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          if (dec_is_start) begin
            start_d = 1'b1;
          end else if (dec_is_illegal) begin
            err_d = 1'b1;
          end else if (|dec_ch) begin
            state_d = StXfer;
            addr_d  = uio_in[ADDR_W-1:0];
            ch_d    = dec_ch;
`ifdef DMA_BURST_EN
            cnt_d   = len_in;
`endif
          end
        end
      end
      StXfer: begin
        if (mem_ready) begin
          if (last_beat) begin
            state_d = StDone;
            addr_d  = '0;
            ch_d    = '0;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
`ifdef DMA_BURST_EN
            cnt_d  = cnt_q - LEN_W'(1);
`endif
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        addr_d  = '0;
        ch_d    = '0;
      end
    endcase
  end

  // Status outputs are registered from the upcoming state.
  always_comb begin
    valid_d = (state_d == StXfer);
    done_d  = (state_d == StDone);
    ready_d = (state_d == StIdle);
  end

  // Single state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      ch_q    <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
`ifdef DMA_BURST_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ch_q    <= ch_d;
      start_q <= start_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      ready_q <= ready_d;
`ifdef DMA_BURST_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign cmd_ready   = ready_q;
  assign fetch       = ch_q;
  assign dma_valid   = valid_q;
  assign dma_address = addr_q;
  assign start       = start_q;
  assign busy        = valid_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_dma_burst_ctrl.sv
// Self-checking bench for dma_burst_ctrl (default parameters). Expected beats are
// derived from the command rules; honours DMA_BURST_EN to pick the beat count.
module tb_dma_burst_ctrl;

`ifdef DMA_BURST_EN
  localparam bit Burst = 1'b1;
`else
  localparam bit Burst = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] uio_in;
  logic [3:0] len_in;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       mem_ready;
  logic [2:0] fetch;
  logic       dma_valid;
  logic [3:0] dma_address;
  logic       start;
  logic       busy;
  logic       done;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;

  dma_burst_ctrl #(
    .NUM_CH (3),
    .ADDR_W (4),
    .LEN_W  (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .uio_in      (uio_in),
    .len_in      (len_in),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .mem_ready   (mem_ready),
    .fetch       (fetch),
    .dma_valid   (dma_valid),
    .dma_address (dma_address),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Observed word: {ready, valid, busy, done, start, err, fetch[2:0], addr[3:0]}
  logic [12:0] obs;
  assign obs = {cmd_ready, dma_valid, busy, done, start, err, fetch, dma_address};

  function automatic logic [12:0] pk(input bit rdy, input bit vld, input bit bsy, input bit dn,
                                     input bit st, input bit er, input logic [2:0] f,
                                     input logic [3:0] a);
    return {rdy, vld, bsy, dn, st, er, f, a};
  endfunction

  localparam logic [12:0] IdleWord = 13'b1_0000_0000_0000;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (rdy,vld,bsy,done,start,err,fetch,addr)",
               tag, got, exp);
    end
  endtask

  // Issue a fetch command and follow it beat by beat. stall_beat/stall_cyc force
  // mem_ready low on one beat; rnd adds random stalls and random ignored commands.
  task automatic do_fetch(input string tag, input logic [7:0] cmd, input logic [3:0] len,
                          input int stall_beat, input int stall_cyc, input bit rnd);
    int         beats;
    int         stalls;
    logic [2:0] oh;
    logic [3:0] base;
    logic [3:0] exp_addr;
    beats = Burst ? int'(len) + 1 : 1;
    oh    = 3'(1 << (int'(cmd[7:5]) - 1));
    base  = cmd[3:0];
    check_eq({tag, ":ready"}, 32'(obs), 32'(IdleWord));
    cmd_valid = 1'b1;
    uio_in    = cmd;
    len_in    = len;
    mem_ready = 1'b0;
    @(negedge clk);
    for (int b = 0; b < beats; b++) begin
      stalls = (b == stall_beat) ? stall_cyc : 0;
      if (rnd) stalls = int'($urandom_range(0, 2));
      exp_addr = base + 4'(b);
      for (int s = 0; s <= stalls; s++) begin
        check_eq($sformatf("%s:beat%0d", tag, b), 32'(obs),
                 32'(pk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, oh, exp_addr)));
        // Commands during a transfer must be dropped.
        cmd_valid = rnd ? 1'($urandom) : 1'b0;
        uio_in    = 8'($urandom);
        len_in    = 4'($urandom);
        mem_ready = (s == stalls);
        @(negedge clk);
      end
    end
    check_eq({tag, ":done"}, 32'(obs), 32'(pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b0, 4'h0)));
    cmd_valid = 1'b0;
    mem_ready = 1'($urandom);
    @(negedge clk);
    check_eq({tag, ":idle"}, 32'(obs), 32'(IdleWord));
  endtask

  // Non-fetch command: expect only the given one-cycle pulse while staying idle.
  task automatic do_simple(input string tag, input logic [7:0] cmd, input bit st, input bit er);
    cmd_valid = 1'b1;
    uio_in    = cmd;
    len_in    = 4'($urandom);
    mem_ready = 1'($urandom);
    @(negedge clk);
    check_eq({tag, ":pulse"}, 32'(obs),
             32'(pk(1'b1, 1'b0, 1'b0, 1'b0, st, er, 3'b0, 4'h0)));
    cmd_valid = 1'b0;
    @(negedge clk);
    check_eq({tag, ":after"}, 32'(obs), 32'(IdleWord));
  endtask

  initial begin
    logic [2:0] op;
    logic [7:0] cmd;
    rst_n     = 1'b0;
    uio_in    = 8'h00;
    len_in    = 4'h0;
    cmd_valid = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("reset", 32'(obs), 32'(IdleWord));
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_reset", 32'(obs), 32'(IdleWord));

    // Directed bursts, including address wrap and a three-cycle stall on beat 2.
    do_fetch("ch0_base5", 8'h25, 4'd3, -1, 0, 1'b0);
    do_fetch("ch1_wrap", 8'h4E, 4'd2, -1, 0, 1'b0);
    do_fetch("stall", 8'h25, 4'd3, 1, 3, 1'b0);
    do_fetch("len7", 8'h6A, 4'd7, -1, 0, 1'b0);

    // START, illegal opcodes and NOP.
    do_simple("start", 8'h80, 1'b1, 1'b0);
    do_simple("illegal7", 8'hE0, 1'b0, 1'b1);
    do_simple("illegal5", 8'hA3, 1'b0, 1'b1);
    do_simple("nop", 8'h1F, 1'b0, 1'b0);

    // Reset during the second beat (held first beat when bursts are off).
    cmd_valid = 1'b1;
    uio_in    = 8'h25;
    len_in    = 4'd3;
    mem_ready = Burst;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("rst:beat0", 32'(obs), 32'(pk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 4'h5)));
    @(negedge clk);
    check_eq("rst:beat1", 32'(obs),
             32'(pk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, Burst ? 4'h6 : 4'h5)));
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    check_eq("rst:abandon", 32'(obs), 32'(IdleWord));
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst:no_done", 32'(obs), 32'(IdleWord));

    // Random command mix with random stalls.
    for (int i = 0; i < 40; i++) begin
      op  = 3'($urandom_range(0, 7));
      cmd = {op, 5'($urandom)};
      if (op >= 3'd1 && op <= 3'd3) begin
        do_fetch($sformatf("rnd%0d", i), cmd, 4'($urandom), -1, 0, 1'b1);
      end else if (op == 3'd4) begin
        do_simple($sformatf("rnd%0d_start", i), cmd, 1'b1, 1'b0);
      end else if (op == 3'd0) begin
        do_simple($sformatf("rnd%0d_nop", i), cmd, 1'b0, 1'b0);
      end else begin
        do_simple($sformatf("rnd%0d_err", i), cmd, 1'b0, 1'b1);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dma_burst_ctrl.md
DMA_BURST_CTRL -- requirements
Module: dma_burst_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 3: number of fetch channels (weights, inputs, instructions), legal range 1..5.
REQ-002 The block SHALL have parameter ADDR_W, default 4: width of the memory address.
REQ-003 The block SHALL have parameter LEN_W, default 4: width of the burst-length field.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port uio_in, input, 8 bits: the host command byte; [7:5] is the opcode, [ADDR_W-1:0] is the base address (ADDR_W<=5).
REQ-007 The block SHALL have port len_in, input, LEN_W bits: burst length minus one.
REQ-008 The block SHALL have port cmd_valid, input, 1 bit: the host command strobe.
REQ-009 The block SHALL have port cmd_ready, output, 1 bit: the block can accept a command.
REQ-010 The block SHALL have port mem_ready, input, 1 bit: the memory accepts the current beat.
REQ-011 The block SHALL have port fetch, output, NUM_CH bits: one-hot active channel, valid with dma_valid.
REQ-012 The block SHALL have port dma_valid, output, 1 bit: a beat is presented.
REQ-013 The block SHALL have port dma_address, output, ADDR_W bits: the beat address.
REQ-014 The block SHALL have ports start, busy, done and err, outputs, 1 bit each: compute-start pulse, transfer in progress, burst-complete pulse, and illegal-opcode pulse.

Function
REQ-015 Opcodes SHALL decode as: 0 = NOP; 1..NUM_CH = fetch on channel opcode-1; NUM_CH+1 = START; NUM_CH+2..7 = illegal. With NUM_CH=3, START is 3'b100.
REQ-016 The FSM SHALL have exactly three states, IDLE, XFER and DONE; cmd_ready SHALL be 1 only in IDLE.
REQ-017 A command SHALL be accepted when cmd_valid and cmd_ready are both 1 at a rising edge; cmd_valid in any other state SHALL be ignored and not queued.
REQ-018 Accepting a fetch command SHALL capture the channel, the base address and len_in+1 beats, and SHALL move the FSM to XFER; the first beat SHALL appear in the next cycle.
REQ-019 In XFER, the outputs SHALL be dma_valid=1, busy=1, fetch one-hot, and dma_address equal to the current address.
REQ-020 A beat SHALL complete at an edge where mem_ready=1; the address SHALL then increment modulo 2^ADDR_W (wrap 4'hF -> 4'h0) and the remaining count SHALL decrement.
REQ-021 While mem_ready=0, dma_address and fetch SHALL hold.
REQ-022 When the last beat completes, the FSM SHALL go to DONE for one cycle: done=1, dma_valid=0, then return to IDLE.
REQ-023 Accepting START SHALL pulse start=1 for exactly one cycle after the edge and SHALL remain in IDLE.
REQ-024 Accepting an illegal opcode SHALL pulse err=1 for one cycle and SHALL remain in IDLE; NOP SHALL be accepted with no effect.
REQ-025 Outside XFER, fetch SHALL be 0 and dma_address SHALL be 0.

Reset
REQ-026 When rst_n=0 at an edge, the FSM SHALL go to IDLE and, from the next cycle, fetch, dma_valid, dma_address, start, busy, done and err SHALL be 0 and cmd_ready SHALL be 1.
REQ-027 Reset asserted mid-burst SHALL abandon the burst with no done pulse.

Configuration
REQ-028 The feature macro SHALL be DMA_BURST_EN. When it is defined, burst length is len_in+1. When it is undefined, len_in is ignored, every fetch is exactly one beat, and the length counter is not instantiated.

Structure
REQ-029 Package dma_pkg SHALL hold the opcode constants, the FSM state enum, and a function that returns the START opcode from NUM_CH.
REQ-030 Opcode decode SHALL be a combinational sub-module, dma_cmd_decode, that produces a channel one-hot and is_start/is_illegal/is_nop flags.

Verification
REQ-031 The bench SHALL cover: NUM_CH=3, uio_in=8'h25, len_in=3, mem_ready=1 -> fetch=3'b001 on addresses 5,6,7,8 in consecutive cycles, then done for one cycle.
REQ-032 The bench SHALL cover: uio_in=8'h4E, len_in=2 -> fetch=3'b010 on addresses 14,15,0.
REQ-033 The bench SHALL cover: mem_ready=0 for 3 cycles on beat 2 -> address held, 4 beats total, done delayed 3 cycles.
REQ-034 The bench SHALL cover: uio_in=8'h80 -> one-cycle start pulse with no dma_valid; uio_in=8'hE0 -> err pulse with no other output.
REQ-035 The bench SHALL cover: rst_n=0 during beat 2 -> all outputs 0 and cmd_ready=1 in the next cycle, and no done pulse.
REQ-036 The bench SHALL cover: DMA_BURST_EN undefined, len_in=7 -> exactly one beat, then done.
